seq_pc_state_reg: RTL and testbench

Architectural state register for the SEQ Y86-64 core, directly downstream of the PC-update stage. Each RUN cycle it commits the combinational next-PC `p_ctr_final` into the program counter. It folds fetch/memory error flags and the halt opcode into the Y86 status code, and stops the machine on any non-AOK status. It also keeps saturating cycle and retired-instruction counters for bench and debug visibility.

---
 rtl/seq_pc_state_reg.sv | 116 +++++++++++
 tb/tb_seq_pc_state_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pc_state_reg.sv
// Architectural PC/status register for the SEQ Y86-64 core.
// Commits the next PC each RUN cycle, folds fault/halt into stat, and keeps saturating counters.
module seq_pc_state_reg #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      p_ctr_final,
    input  logic [3:0]       in_code,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             dmem_error,
    output logic [63:0]      pc,
    output logic [1:0]       stat,
    output logic             running,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [1:0] StatAok = 2'd0;
    localparam logic [1:0] StatHlt = 2'd1;
    localparam logic [1:0] StatAdr = 2'd2;
    localparam logic [1:0] StatIns = 2'd3;
    localparam logic [3:0] IcodeHalt = 4'h0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStop
    } state_e;

    state_e           r_state;
    logic [63:0]      r_pc;
    logic [1:0]       r_stat;
    logic [CNT_W-1:0] r_cycle;
    logic [CNT_W-1:0] r_retired;

    state_e           w_state_d;
    logic [63:0]      w_pc_d;
    logic [1:0]       w_stat_d;
    logic [CNT_W-1:0] w_cycle_d;
    logic [CNT_W-1:0] w_retired_d;
    logic [CNT_W-1:0] w_cycle_sat;
    logic [CNT_W-1:0] w_retired_sat;

    // Counters stick at all-ones rather than wrapping.
    assign w_cycle_sat   = (&r_cycle)   ? r_cycle   : r_cycle + CNT_W'(1);
    assign w_retired_sat = (&r_retired) ? r_retired : r_retired + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= StIdle;
            r_pc      <= RESET_PC;
            r_stat    <= StatAok;
            r_cycle   <= '0;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_d;
            r_pc      <= w_pc_d;
            r_stat    <= w_stat_d;
            r_cycle   <= w_cycle_d;
            r_retired <= w_retired_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_pc_d      = r_pc;
        w_stat_d    = r_stat;
        w_cycle_d   = r_cycle;
        w_retired_d = r_retired;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                w_cycle_d = w_cycle_sat;
                // Stopping conditions leave pc on the faulting/halting instruction.
                if (imem_error) begin
                    w_stat_d  = StatAdr;
                    w_state_d = StStop;
                end else if (!instr_valid) begin
                    w_stat_d  = StatIns;
                    w_state_d = StStop;
                end else if (dmem_error) begin
                    w_stat_d  = StatAdr;
                    w_state_d = StStop;
                end else if (in_code == IcodeHalt) begin
                    w_stat_d    = StatHlt;
                    w_retired_d = w_retired_sat;
                    w_state_d   = StStop;
                end else begin
                    w_pc_d      = p_ctr_final;
                    w_retired_d = w_retired_sat;
                end
            end
            StStop: begin
                w_state_d = StStop;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign pc            = r_pc;
    assign stat          = r_stat;
    assign running       = (r_state == StRun);
    assign cycle_count   = r_cycle;
    assign retired_count = r_retired;

endmodule

// File: tb/tb_seq_pc_state_reg.sv
// Self-checking bench: two DUT configurations share stimulus and are compared every cycle
// against a behavioural model; directed scenarios add literal expectations.
module tb_seq_pc_state_reg;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [63:0] p_ctr_final = '0;
    logic [3:0]  in_code = 4'h1;
    logic        instr_valid = 1'b1;
    logic        imem_error = 1'b0;
    logic        dmem_error = 1'b0;

    logic [63:0] a_pc, b_pc;
    logic [1:0]  a_stat, b_stat;
    logic        a_running, b_running;
    logic [31:0] a_cyc, a_ret;
    logic [2:0]  b_cyc, b_ret;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    always #5 clock = ~clock;

    seq_pc_state_reg #(.RESET_PC(64'h0), .CNT_W(32)) u_a (
        .clock(clock), .reset(reset), .start(start), .p_ctr_final(p_ctr_final),
        .in_code(in_code), .instr_valid(instr_valid), .imem_error(imem_error),
        .dmem_error(dmem_error), .pc(a_pc), .stat(a_stat), .running(a_running),
        .cycle_count(a_cyc), .retired_count(a_ret)
    );

    seq_pc_state_reg #(.RESET_PC(64'h100), .CNT_W(3)) u_b (
        .clock(clock), .reset(reset), .start(start), .p_ctr_final(p_ctr_final),
        .in_code(in_code), .instr_valid(instr_valid), .imem_error(imem_error),
        .dmem_error(dmem_error), .pc(b_pc), .stat(b_stat), .running(b_running),
        .cycle_count(b_cyc), .retired_count(b_ret)
    );

    // Behavioural model: mode 0 idle, 1 run, 2 stopped; index 0 = u_a, 1 = u_b.
    longint unsigned m_rpc[2] = '{64'h0, 64'h100};
    longint unsigned m_max[2] = '{64'hFFFF_FFFF, 64'h7};
    int              m_mode[2];
    longint unsigned m_pc[2], m_cyc[2], m_ret[2];
    int              m_stat[2];

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_mode[i] = 0; m_pc[i] = m_rpc[i]; m_stat[i] = 0; m_cyc[i] = 0; m_ret[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (start) m_mode[i] = 1;
            end else if (m_mode[i] == 1) begin
                if (m_cyc[i] < m_max[i]) m_cyc[i]++;
                if (imem_error) begin
                    m_stat[i] = 2; m_mode[i] = 2;
                end else if (!instr_valid) begin
                    m_stat[i] = 3; m_mode[i] = 2;
                end else if (dmem_error) begin
                    m_stat[i] = 2; m_mode[i] = 2;
                end else begin
                    if (m_ret[i] < m_max[i]) m_ret[i]++;
                    if (in_code == 4'h0) begin
                        m_stat[i] = 1; m_mode[i] = 2;
                    end else begin
                        m_pc[i] = p_ctr_final;
                    end
                end
            end
        end
    end

    function automatic void chk(string name, longint unsigned act, longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Single compare process, away from the active edge.
    always @(negedge clock) begin
        if (armed) begin
            chk("a.pc", a_pc, m_pc[0]);
            chk("a.stat", 64'(a_stat), 64'(m_stat[0]));
            chk("a.running", 64'(a_running), 64'(m_mode[0] == 1));
            chk("a.cycle", 64'(a_cyc), m_cyc[0]);
            chk("a.retired", 64'(a_ret), m_ret[0]);
            chk("b.pc", b_pc, m_pc[1]);
            chk("b.stat", 64'(b_stat), 64'(m_stat[1]));
            chk("b.running", 64'(b_running), 64'(m_mode[1] == 1));
            chk("b.cycle", 64'(b_cyc), m_cyc[1]);
            chk("b.retired", 64'(b_ret), m_ret[1]);
        end
    end

    task automatic step(input bit rst, input bit st, input logic [63:0] pcf, input logic [3:0] code,
                        input bit iv, input bit ie, input bit de);
        reset = rst; start = st; p_ctr_final = pcf; in_code = code;
        instr_valid = iv; imem_error = ie; dmem_error = de;
        @(posedge clock);
        #2;
    endtask

    task automatic go();
        step(1, 0, 64'h0, 4'h1, 1, 0, 0);
        step(0, 1, 64'h0, 4'h1, 1, 0, 0);
    endtask

    initial begin
        @(posedge clock);
        #2;
        step(1, 0, 64'h0, 4'h1, 1, 0, 0);
        armed = 1'b1;
        chk("reset.pc", a_pc, 64'h0);
        chk("reset.b_pc", b_pc, 64'h100);
        chk("reset.running", 64'(a_running), 0);

        // Directed: three commits then halt.
        step(0, 1, 64'h0, 4'h1, 1, 0, 0);
        chk("start.running", 64'(a_running), 1);
        chk("start.pc", a_pc, 64'h0);
        step(0, 0, 64'h0A, 4'h6, 1, 0, 0);
        chk("commit1.pc", a_pc, 64'h0A);
        step(0, 0, 64'h14, 4'h3, 1, 0, 0);
        chk("commit2.pc", a_pc, 64'h14);
        step(0, 0, 64'h1E, 4'hC, 1, 0, 0);
        chk("commit3.pc", a_pc, 64'h1E);
        step(0, 0, 64'h99, 4'h0, 1, 0, 0);
        chk("halt.pc", a_pc, 64'h1E);
        chk("halt.stat", 64'(a_stat), 1);
        chk("halt.retired", 64'(a_ret), 4);
        chk("halt.cycle", 64'(a_cyc), 4);
        chk("halt.running", 64'(a_running), 0);
        chk("model.retired", m_ret[0], 4);
        for (int i = 0; i < 5; i++) step(0, (i == 0), 64'h500 + 64'(i), 4'h2, 1, 0, 0);
        chk("stop.frozen.pc", a_pc, 64'h1E);
        chk("stop.frozen.cycle", 64'(a_cyc), 4);
        step(1, 0, 64'h0, 4'h1, 1, 0, 0);
        chk("rearm.pc", a_pc, 64'h0);
        chk("rearm.stat", 64'(a_stat), 0);
        chk("rearm.cycle", 64'(a_cyc), 0);

        // imem_error beats INS.
        go();
        step(0, 0, 64'h40, 4'h6, 1, 0, 0);
        step(0, 0, 64'h80, 4'h6, 0, 1, 0);
        chk("imem.stat", 64'(a_stat), 2);
        chk("imem.pc", a_pc, 64'h40);
        chk("imem.retired", 64'(a_ret), 1);

        // INS beats dmem; dmem alone is ADR.
        go();
        step(0, 0, 64'h40, 4'h6, 0, 0, 1);
        chk("ins.stat", 64'(a_stat), 3);
        go();
        step(0, 0, 64'h40, 4'h6, 1, 0, 1);
        chk("dmem.stat", 64'(a_stat), 2);
        chk("dmem.retired", 64'(a_ret), 0);

        // Reset mid-run, then resume.
        go();
        step(0, 0, 64'h10, 4'h6, 1, 0, 0);
        step(0, 0, 64'h20, 4'h6, 1, 0, 0);
        step(1, 0, 64'h30, 4'h6, 1, 0, 0);
        chk("midrst.pc", a_pc, 64'h0);
        chk("midrst.running", 64'(a_running), 0);
        chk("midrst.retired", 64'(a_ret), 0);
        step(0, 1, 64'h0, 4'h6, 1, 0, 0);
        step(0, 0, 64'h50, 4'h6, 1, 0, 0);
        chk("resume.pc", a_pc, 64'h50);

        // Reset together with start stays idle.
        step(1, 1, 64'h0, 4'h6, 1, 0, 0);
        step(0, 0, 64'h60, 4'h6, 1, 0, 0);
        chk("rst_start.running", 64'(a_running), 0);

        // Saturation on the 3-bit instance.
        go();
        for (int i = 0; i < 10; i++) step(0, 0, 64'h200 + 64'(i * 4), 4'h6, 1, 0, 0);
        chk("sat.b_cycle", 64'(b_cyc), 7);
        chk("sat.b_retired", 64'(b_ret), 7);
        chk("sat.b_pc", b_pc, 64'h224);
        chk("sat.b_running", 64'(b_running), 1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            automatic int r = int'($urandom_range(0, 99));
            automatic bit rst = (r < 2);
            automatic bit st = ($urandom_range(0, 9) == 0);
            automatic bit iv = ($urandom_range(0, 39) != 0);
            automatic bit ie = ($urandom_range(0, 39) == 0);
            automatic bit de = ($urandom_range(0, 39) == 0);
            automatic logic [3:0] code = ($urandom_range(0, 19) == 0) ? 4'h0 :
                                         4'($urandom_range(1, 15));
            automatic logic [63:0] pcf = {$urandom, $urandom};
            step(rst, st, pcf, code, iv, ie, de);
        end

        armed = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
